// File: rtl/but_led_mode_ctrl_if.sv
// Button/LED bundle for the LED mode controller.
// Buttons are active-low, and LEDs light when high.
interface but_led_mode_ctrl_if;
  logic BUT1;
  logic BUT2;
  logic LED1;
  logic LED2;

  modport master (output BUT1, output BUT2, input LED1, input LED2);
  modport slave  (input BUT1, input BUT2, output LED1, output LED2);
endinterface

// File: rtl/but_led_mode_ctrl.sv
// Two-button LED mode controller. Each button is synchronised and debounced,
// then each press steps its LED channel through OFF -> ON -> SLOW -> FAST.
module but_led_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SLOW_HALF       = 50000000,
  parameter int FAST_HALF       = 12500000
) (
  input  logic                CLK,
  input  logic                RESET_N,
  but_led_mode_ctrl_if.slave  bus
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = (SLOW_HALF > 1) ? $clog2(SLOW_HALF) : 1;
  localparam int FW = (FAST_HALF > 1) ? $clog2(FAST_HALF) : 1;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_ON   = 2'd1,
    MODE_SLOW = 2'd2,
    MODE_FAST = 2'd3
  } mode_t;

  logic [1:0]    but_vec;
  logic [1:0]    led_reg;
  logic [SW-1:0] slow_cnt_reg;
  logic [FW-1:0] fast_cnt_reg;
  logic          slow_phase_reg;
  logic          fast_phase_reg;

  assign but_vec  = {bus.BUT2, bus.BUT1};
  assign bus.LED1 = led_reg[0];
  assign bus.LED2 = led_reg[1];

  // The blink timebase is shared and free-running, so both channels blink in phase.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      slow_cnt_reg   <= '0;
      fast_cnt_reg   <= '0;
      slow_phase_reg <= 1'b0;
      fast_phase_reg <= 1'b0;
    end else begin
      if (slow_cnt_reg == SW'(SLOW_HALF - 1)) begin
        slow_cnt_reg   <= '0;
        slow_phase_reg <= ~slow_phase_reg;
      end else begin
        slow_cnt_reg <= slow_cnt_reg + SW'(1);
      end
      if (fast_cnt_reg == FW'(FAST_HALF - 1)) begin
        fast_cnt_reg   <= '0;
        fast_phase_reg <= ~fast_phase_reg;
      end else begin
        fast_cnt_reg <= fast_cnt_reg + FW'(1);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic          sync1_reg;
      logic          sync2_reg;
      logic          stable_reg;
      logic          stable_d_reg;
      logic [DW-1:0] db_cnt_reg;
      mode_t         mode_reg;
      logic          press;

      assign press = stable_d_reg & ~stable_reg;

      always_ff @(posedge CLK) begin
        if (!RESET_N) begin
          sync1_reg    <= 1'b1;
          sync2_reg    <= 1'b1;
          stable_reg   <= 1'b1;
          stable_d_reg <= 1'b1;
          db_cnt_reg   <= '0;
        end else begin
          sync1_reg    <= but_vec[gi];
          sync2_reg    <= sync1_reg;
          stable_d_reg <= stable_reg;
          // Any return to the stable level restarts the count, so bounces are rejected.
          if (sync2_reg == stable_reg) begin
            db_cnt_reg <= '0;
          end else if (db_cnt_reg == DW'(DEBOUNCE_CYCLES - 1)) begin
            stable_reg <= sync2_reg;
            db_cnt_reg <= '0;
          end else begin
            db_cnt_reg <= db_cnt_reg + DW'(1);
          end
        end
      end

      always_ff @(posedge CLK) begin
        if (!RESET_N) begin
          mode_reg    <= MODE_OFF;
          led_reg[gi] <= 1'b0;
        end else begin
          if (press) begin
            case (mode_reg)
              MODE_OFF:  mode_reg <= MODE_ON;
              MODE_ON:   mode_reg <= MODE_SLOW;
              MODE_SLOW: mode_reg <= MODE_FAST;
              default:   mode_reg <= MODE_OFF;
            endcase
          end
          case (mode_reg)
            MODE_OFF:  led_reg[gi] <= 1'b0;
            MODE_ON:   led_reg[gi] <= 1'b1;
            MODE_SLOW: led_reg[gi] <= slow_phase_reg;
            default:   led_reg[gi] <= fast_phase_reg;
          endcase
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_but_led_mode_ctrl.sv
// Directed bench for but_led_mode_ctrl with DEBOUNCE_CYCLES=4, SLOW_HALF=8, FAST_HALF=2.
module tb_but_led_mode_ctrl;

  logic clk;
  logic rst_n;
  int   vecs;
  int   errs;
  int   n_edges;

  but_led_mode_ctrl_if bus ();

  but_led_mode_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .SLOW_HALF      (8),
    .FAST_HALF      (2)
  ) dut (
    .CLK    (clk),
    .RESET_N(rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; the first post-reset edge counts as 1.
  always @(posedge clk) n_edges <= rst_n ? n_edges + 1 : 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic press_release(input int which, input int low_cyc, input int high_cyc);
    if (which == 1) bus.BUT1 = 1'b0; else bus.BUT2 = 1'b0;
    repeat (low_cyc) step();
    if (which == 1) bus.BUT1 = 1'b1; else bus.BUT2 = 1'b1;
    repeat (high_cyc) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    vecs++;
    if (bus.LED1 !== 1'b0 || bus.LED2 !== 1'b0) begin
      errs++;
      $display("FAIL reset_state led1=%b led2=%b exp=0/0", bus.LED1, bus.LED2);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      vecs++;
      if (bus.LED1 !== 1'b0 || bus.LED2 !== 1'b0) begin
        errs++;
        $display("FAIL idle_off cyc=%0d led1=%b led2=%b exp=0/0", i, bus.LED1, bus.LED2);
      end
    end
    $display("test_reset done: vecs=%0d errs=%0d", vecs, errs);
  endtask

  task automatic test_press_latency();
    logic e;
    bus.BUT1 = 1'b0;
    for (int i = 0; i <= 7; i++) begin
      step();
      e = (i == 7);
      vecs++;
      if (bus.LED1 !== e || bus.LED2 !== 1'b0) begin
        errs++;
        $display("FAIL press_latency edge=%0d led1=%b exp=%b led2=%b exp=0", i, bus.LED1, e, bus.LED2);
      end
    end
    for (int i = 0; i < 100; i++) begin
      step();
      vecs++;
      if (bus.LED1 !== 1'b1 || bus.LED2 !== 1'b0) begin
        errs++;
        $display("FAIL hold_single cyc=%0d led1=%b exp=1 led2=%b exp=0", i, bus.LED1, bus.LED2);
      end
    end
    bus.BUT1 = 1'b1;
    repeat (10) step();
    vecs++;
    if (bus.LED1 !== 1'b1) begin
      errs++;
      $display("FAIL release_no_change led1=%b exp=1", bus.LED1);
    end
    $display("test_press_latency done: vecs=%0d errs=%0d", vecs, errs);
  endtask

  task automatic test_mode_cycle();
    logic e;
    do_reset();
    press_release(1, 10, 10);
    press_release(1, 10, 10);
    for (int i = 0; i < 24; i++) begin
      step();
      e = 1'(((n_edges - 1) / 8) % 2);
      vecs++;
      if (bus.LED1 !== e || bus.LED2 !== 1'b0) begin
        errs++;
        $display("FAIL slow_blink n=%0d led1=%b exp=%b led2=%b", n_edges, bus.LED1, e, bus.LED2);
      end
    end
    press_release(1, 10, 10);
    for (int i = 0; i < 12; i++) begin
      step();
      e = 1'(((n_edges - 1) / 2) % 2);
      vecs++;
      if (bus.LED1 !== e) begin
        errs++;
        $display("FAIL fast_blink n=%0d led1=%b exp=%b", n_edges, bus.LED1, e);
      end
    end
    press_release(1, 10, 10);
    for (int i = 0; i < 12; i++) begin
      step();
      vecs++;
      if (bus.LED1 !== 1'b0 || bus.LED2 !== 1'b0) begin
        errs++;
        $display("FAIL wrap_off cyc=%0d led1=%b led2=%b exp=0/0", i, bus.LED1, bus.LED2);
      end
    end
    $display("test_mode_cycle done: vecs=%0d errs=%0d", vecs, errs);
  endtask

  task automatic test_bounce();
    press_release(2, 3, 1);
    press_release(2, 3, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      vecs++;
      if (bus.LED2 !== 1'b0) begin
        errs++;
        $display("FAIL bounce_reject cyc=%0d led2=%b exp=0", i, bus.LED2);
      end
    end
    press_release(2, 4, 12);
    vecs++;
    if (bus.LED2 !== 1'b1 || bus.LED1 !== 1'b0) begin
      errs++;
      $display("FAIL min_pulse led2=%b exp=1 led1=%b exp=0", bus.LED2, bus.LED1);
    end
    $display("test_bounce done: vecs=%0d errs=%0d", vecs, errs);
  endtask

  task automatic test_simultaneous();
    logic e;
    do_reset();
    bus.BUT1 = 1'b0;
    bus.BUT2 = 1'b0;
    for (int i = 0; i <= 7; i++) begin
      step();
      e = (i == 7);
      vecs++;
      if (bus.LED1 !== e || bus.LED2 !== e) begin
        errs++;
        $display("FAIL simul_latency edge=%0d led1=%b led2=%b exp=%b", i, bus.LED1, bus.LED2, e);
      end
    end
    repeat (3) step();
    bus.BUT1 = 1'b1;
    bus.BUT2 = 1'b1;
    repeat (10) step();
    vecs++;
    if (bus.LED1 !== 1'b1 || bus.LED2 !== 1'b1) begin
      errs++;
      $display("FAIL simul_on led1=%b led2=%b exp=1/1", bus.LED1, bus.LED2);
    end
    $display("test_simultaneous done: vecs=%0d errs=%0d", vecs, errs);
  endtask

  task automatic test_reset_mid_op();
    logic e;
    press_release(1, 10, 10);
    bus.BUT1 = 1'b0;
    repeat (7) step();
    for (int i = 0; i < 6; i++) begin
      step();
      e = 1'(((n_edges - 1) / 2) % 2);
      vecs++;
      if (bus.LED1 !== e || bus.LED2 !== 1'b1) begin
        errs++;
        $display("FAIL pre_reset_fast n=%0d led1=%b exp=%b led2=%b exp=1", n_edges, bus.LED1, e, bus.LED2);
      end
    end
    rst_n = 1'b0;
    step();
    vecs++;
    if (bus.LED1 !== 1'b0 || bus.LED2 !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset led1=%b led2=%b exp=0/0", bus.LED1, bus.LED2);
    end
    rst_n = 1'b1;
    for (int i = 0; i <= 7; i++) begin
      step();
      e = (i == 7);
      vecs++;
      if (bus.LED1 !== e || bus.LED2 !== 1'b0) begin
        errs++;
        $display("FAIL held_after_reset edge=%0d led1=%b exp=%b led2=%b exp=0", i, bus.LED1, e, bus.LED2);
      end
    end
    repeat (5) step();
    vecs++;
    if (bus.LED1 !== 1'b1) begin
      errs++;
      $display("FAIL held_after_reset_on led1=%b exp=1", bus.LED1);
    end
    bus.BUT1 = 1'b1;
    repeat (10) step();
    $display("test_reset_mid_op done: vecs=%0d errs=%0d", vecs, errs);
  endtask

  initial begin
    vecs     = 0;
    errs     = 0;
    rst_n    = 1'b0;
    bus.BUT1 = 1'b1;
    bus.BUT2 = 1'b1;
    test_reset();
    test_press_latency();
    test_mode_cycle();
    test_bounce();
    test_simultaneous();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
